// File: rtl/zmc2_pack_pkg.sv
// Shared definitions for the ZMC2 pixel-pair packer: word geometry, the
// FIFO payload type and the planar pack-index helpers.
package zmc2_pack_pkg;

  localparam int unsigned PIX_PER_WORD   = 8;
  localparam int unsigned BPP            = 4;
  localparam int unsigned BEATS_PER_WORD = 4;
  localparam int unsigned FIFO_DEPTH     = 2;
  localparam int unsigned CR_W           = PIX_PER_WORD * BPP;
  localparam int unsigned BEAT_W         = 2;
  localparam int unsigned PIX_IDX_W      = 3;
  localparam int unsigned CR_IDX_W       = 5;
  localparam int unsigned WORD_W         = CR_W + PIX_PER_WORD;

  // One packed output word: planar colour bits plus per-pixel opaque mask.
  typedef struct packed {
    logic [CR_W-1:0]         cr;
    logic [PIX_PER_WORD-1:0] opq;
  } word_t;

  // Display slot of pixel p, mirrored when flip is set.
  function automatic logic [PIX_IDX_W-1:0] pix_slot(input logic [PIX_IDX_W-1:0] pix,
                                                    input logic                 flip);
    return flip ? PIX_IDX_W'(3'd7 - pix) : pix;
  endfunction

  // CR bit index for colour bit k of pixel p: plane k occupies CR[8k+7:8k].
  function automatic logic [CR_IDX_W-1:0] pack_idx(input logic [PIX_IDX_W-1:0] pix,
                                                   input logic [1:0]           bit_k,
                                                   input logic                 flip);
    return {bit_k, pix_slot(pix, flip)};
  endfunction

endpackage

// File: rtl/zmc2_pack_fifo.sv
// Two-entry output FIFO for packed words. Head data, valid and count are all
// registered; full_next_c is the occupancy the FIFO will have after this edge.
// Ports: clk, reset (sync, active-high), push/push_data, pop,
//        valid (not empty), head (oldest entry), full_next_c.
module zmc2_pack_fifo
  import zmc2_pack_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  word_t push_data,
  input  logic  pop,
  output logic  valid,
  output word_t head,
  output logic  full_next_c
);

  word_t      mem_q [FIFO_DEPTH];
  word_t      mem_n [FIFO_DEPTH];
  logic       wr_q, wr_n, rd_q, rd_n;
  logic [1:0] cnt_q, cnt_n;
  logic       do_push, do_pop;

  // Next-state: guarded push/pop, pointers wrap modulo 2.
  always_comb begin
    mem_n   = mem_q;
    wr_n    = wr_q;
    rd_n    = rd_q;
    do_push = push && (cnt_q != 2'd2);
    do_pop  = pop && (cnt_q != 2'd0);
    if (do_push) begin
      mem_n[wr_q] = push_data;
      wr_n        = ~wr_q;
    end
    if (do_pop) begin
      rd_n = ~rd_q;
    end
    cnt_n       = cnt_q + 2'(do_push) - 2'(do_pop);
    full_next_c = (cnt_n == 2'd2);
  end

  // State register; head is preloaded from the next-state view so it stays registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
      valid    <= 1'b0;
      head     <= '0;
    end else begin
      mem_q    <= mem_n;
      wr_q     <= wr_n;
      rd_q     <= rd_n;
      cnt_q    <= cnt_n;
      valid    <= (cnt_n != 2'd0);
      head     <= mem_n[rd_n];
    end
  end

endmodule

// File: rtl/zmc2_pack.sv
// Packs a stream of pixel pairs (4 beats, 8 pixels of 4 bpp) into ZMC2 planar
// words with an opaque mask, optionally mirrored, and queues them in a 2-entry FIFO.
// Ports: clk, reset (sync, active-high), sync (restart word), in_valid/in_ready,
//        pix_a/pix_b (even/odd pixel), flip, out_valid/out_ready, cr, opq.
module zmc2_pack
  import zmc2_pack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BPP-1:0]    pix_a,
  input  logic [BPP-1:0]    pix_b,
  input  logic              flip,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CR_W-1:0]   cr,
  output logic [PIX_PER_WORD-1:0] opq
);

  logic [BEAT_W-1:0]    beat_q, beat_n, beat_idx;
  logic                 flip_q, flip_n, flip_use;
  word_t                asm_q, asm_n, head;
  logic                 in_ready_q;
  logic                 xfer, push, pop, full_next_c;
  logic [PIX_IDX_W-1:0] p_even, p_odd;

  // Beat assembly: sync forces the current transfer to be beat 0.
  always_comb begin
    beat_idx = sync ? '0 : beat_q;
    xfer     = in_valid && in_ready_q;
    flip_use = (beat_idx == '0) ? flip : flip_q;
    p_even   = {beat_idx, 1'b0};
    p_odd    = {beat_idx, 1'b1};
    asm_n    = asm_q;
    if (xfer) begin
      for (int unsigned k = 0; k < BPP; k++) begin
        asm_n.cr[pack_idx(p_even, 2'(k), flip_use)] = pix_a[k];
        asm_n.cr[pack_idx(p_odd,  2'(k), flip_use)] = pix_b[k];
      end
      asm_n.opq[pix_slot(p_even, flip_use)] = |pix_a;
      asm_n.opq[pix_slot(p_odd,  flip_use)] = |pix_b;
    end
    push   = xfer && (beat_idx == 2'd3);
    beat_n = beat_q;
    if (xfer) begin
      beat_n = beat_idx + 2'd1;
    end else if (sync) begin
      beat_n = '0;
    end
    flip_n = (xfer && (beat_idx == '0)) ? flip : flip_q;
  end

  // Ready is precomputed from next state, so it never depends on out_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q     <= '0;
      flip_q     <= 1'b0;
      asm_q      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      beat_q     <= beat_n;
      flip_q     <= flip_n;
      asm_q      <= asm_n;
      in_ready_q <= !((beat_n == 2'd3) && full_next_c);
    end
  end

  assign pop = out_valid && out_ready;

  zmc2_pack_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (asm_n),
    .pop         (pop),
    .valid       (out_valid),
    .head        (head),
    .full_next_c (full_next_c)
  );

  assign in_ready = in_ready_q;
  assign cr       = head.cr;
  assign opq      = head.opq;

endmodule

// File: tb/tb_zmc2_pack.sv
// Directed bench for zmc2_pack: hand-computed planar words, back-pressure,
// sync and reset behaviour.
module tb_zmc2_pack;

  logic        clk = 1'b0;
  logic        reset, sync, in_valid, in_ready, flip, out_valid, out_ready;
  logic [3:0]  pix_a, pix_b;
  logic [31:0] cr;
  logic [7:0]  opq;

  int nvec  = 0;
  int nfail = 0;

  localparam logic [31:0] W_PLAIN = 32'h8078_6655;
  localparam logic [31:0] W_FLIP  = 32'h011E_66AA;
  localparam logic [31:0] W_PIX5  = 32'h2020_2020;

  always #5 clk = ~clk;

  zmc2_pack dut (
    .clk       (clk),
    .reset     (reset),
    .sync      (sync),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pix_a     (pix_a),
    .pix_b     (pix_b),
    .flip      (flip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cr        (cr),
    .opq       (opq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat; waits (bounded) for in_ready.
  task automatic send_beat(input logic [3:0] a, input logic [3:0] b,
                           input logic f, input logic s);
    int n = 0;
    pix_a = a; pix_b = b; flip = f; sync = s; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; sync = 1'b0; flip = 1'b0;
  endtask

  task automatic send_plain(input logic f);
    send_beat(4'd1, 4'd2, f, 1'b0);
    send_beat(4'd3, 4'd4, 1'b0, 1'b0);
    send_beat(4'd5, 4'd6, 1'b0, 1'b0);
    send_beat(4'd7, 4'd8, 1'b0, 1'b0);
  endtask

  task automatic send_pix5();
    send_beat(4'd0, 4'd0, 1'b0, 1'b0);
    send_beat(4'd0, 4'd0, 1'b0, 1'b0);
    send_beat(4'd0, 4'hF, 1'b0, 1'b0);
    send_beat(4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sync = 1'b0; in_valid = 1'b0; flip = 1'b0;
    out_ready = 1'b0; pix_a = '0; pix_b = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_cr",        cr,             32'd0);
    check("rst_opq",       32'(opq),       32'd0);

    // Plain, flipped and single-pixel words with the consumer always ready.
    out_ready = 1'b1;
    send_plain(1'b0);
    check("plain_valid", 32'(out_valid), 32'd1);
    check("plain_cr",    cr,             W_PLAIN);
    check("plain_opq",   32'(opq),       32'hFF);
    tick();
    check("plain_popped", 32'(out_valid), 32'd0);

    send_plain(1'b1);
    check("flip_cr",  cr,       W_FLIP);
    check("flip_opq", 32'(opq), 32'hFF);
    tick();

    send_pix5();
    check("pix5_cr",  cr,       W_PIX5);
    check("pix5_opq", 32'(opq), 32'h20);
    tick();

    // Back-pressure: two words buffered, third blocks at its last beat.
    out_ready = 1'b0;
    send_plain(1'b0);
    send_plain(1'b1);
    check("bp_head_w1", cr, W_PLAIN);
    send_beat(4'd0, 4'd0, 1'b0, 1'b0);
    send_beat(4'd0, 4'd0, 1'b0, 1'b0);
    send_beat(4'd0, 4'hF, 1'b0, 1'b0);
    check("bp_ready_low", 32'(in_ready), 32'd0);
    pix_a = 4'd0; pix_b = 4'd0; in_valid = 1'b1;
    tick();
    tick();
    check("bp_still_low", 32'(in_ready), 32'd0);
    check("bp_stable_cr", cr,             W_PLAIN);
    out_ready = 1'b1;
    tick();
    check("bp_head_w2",  cr,             W_FLIP);
    check("bp_ready_up", 32'(in_ready),  32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_head_w3",  cr,             W_PIX5);
    check("bp_w3_opq",   32'(opq),       32'h20);
    tick();
    check("bp_drained",  32'(out_valid), 32'd0);

    // Partial word discarded by a lone sync.
    send_beat(4'd9, 4'd9, 1'b0, 1'b0);
    send_beat(4'd9, 4'd9, 1'b0, 1'b0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_no_word", 32'(out_valid), 32'd0);
    send_plain(1'b0);
    check("sync_word_cr", cr,             W_PLAIN);
    tick();
    check("sync_one_word", 32'(out_valid), 32'd0);

    // Sync with a transfer: that beat is beat 0 and samples flip.
    send_beat(4'd9, 4'd9, 1'b0, 1'b0);
    send_beat(4'd9, 4'd9, 1'b0, 1'b0);
    send_beat(4'd1, 4'd2, 1'b1, 1'b1);
    send_beat(4'd3, 4'd4, 1'b0, 1'b0);
    send_beat(4'd5, 4'd6, 1'b0, 1'b0);
    send_beat(4'd7, 4'd8, 1'b0, 1'b0);
    check("syncx_cr",  cr,       W_FLIP);
    check("syncx_opq", 32'(opq), 32'hFF);
    tick();

    // Sync while blocked at beat 3 with the FIFO full: no transfer, counter restarts.
    out_ready = 1'b0;
    send_plain(1'b0);
    send_pix5();
    send_beat(4'd1, 4'd1, 1'b0, 1'b0);
    send_beat(4'd1, 4'd1, 1'b0, 1'b0);
    send_beat(4'd1, 4'd1, 1'b0, 1'b0);
    check("blk_ready_low", 32'(in_ready), 32'd0);
    sync = 1'b1; in_valid = 1'b1;
    tick();
    sync = 1'b0; in_valid = 1'b0;
    check("blk_sync_ready", 32'(in_ready), 32'd1);
    check("blk_head_kept",  cr,            W_PLAIN);
    do_reset();

    // Reset mid-word with one word queued.
    send_plain(1'b1);
    send_beat(4'd5, 4'd5, 1'b0, 1'b0);
    send_beat(4'd5, 4'd5, 1'b0, 1'b0);
    reset = 1'b1; sync = 1'b1;
    tick();
    reset = 1'b0; sync = 1'b0;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready",  32'(in_ready),  32'd1);
    check("mrst_cr",        cr,             32'd0);
    out_ready = 1'b1;
    send_pix5();
    check("mrst_word_cr",  cr,       W_PIX5);
    check("mrst_word_opq", 32'(opq), 32'h20);
    tick();
    check("mrst_drained", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/zmc2_pack.md
ZMC2_PACK -- requirements
Module: zmc2_pack

Interface
REQ-001 Parameters: none; the word format is fixed at 8 pixels × 4 bpp = 32 bits, planar.
REQ-002 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 RESET  in  1  synchronous reset, active-high.
REQ-004 SYNC  in  1  discards any partial word and restarts the beat count at 0.
REQ-005 IN_VALID  in  1  the pixel pair on PIX_A/PIX_B is valid.
REQ-006 IN_READY  out  1  the block accepts a pair this cycle.
REQ-007 PIX_A  in  4  color index of the even pixel (2n) of the pair.
REQ-008 PIX_B  in  4  color index of the odd pixel (2n+1) of the pair.
REQ-009 FLIP  in  1  horizontal mirror; sampled on beat 0 and held for the whole word.
REQ-010 OUT_VALID  out  1  a packed word is available.
REQ-011 OUT_READY  in  1  the consumer takes the word this cycle.
REQ-012 CR  out  32  packed planar word, in the format the ZMC2 dot shifter loads.
REQ-013 OPQ  out  8  per-pixel opaque mask; bit p = (pixel p color != 0).

Function
REQ-014 A transfer occurs when IN_VALID and IN_READY are both high; each transfer is one beat, and 4 beats make one word (pixels 0..7 in display order).
REQ-015 Beat b supplies pixels 2b (PIX_A) and 2b+1 (PIX_B).
REQ-016 Packing, FLIP=0: pixel p, color bit k -> CR[8k+p].
REQ-017 Packing, FLIP=1: pixel p -> slot q=7-p, color bit k -> CR[8k+q]; OPQ bit q is flipped likewise.
REQ-018 The beat counter is 2 bits, 0..3, and wraps to 0 after beat 3.
REQ-019 The assembly register is 32 bits plus an 8-bit mask; each beat writes only its own bit positions.
REQ-020 On the cycle beat 3 transfers, the completed word and mask are pushed into a 2-entry output FIFO; OUT_VALID is high the following cycle (latency 1 from the last beat).
REQ-021 IN_READY = NOT(beat counter == 3 AND FIFO full); beats 0..2 are always accepted.
REQ-022 IN_READY has no combinational path from OUT_READY; a pop in the same cycle does not free a slot until the next cycle.
REQ-023 OUT_VALID = FIFO not empty; CR/OPQ show the head entry and stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-024 Pop occurs when OUT_VALID and OUT_READY are both high; a simultaneous push and pop on a 1-entry FIFO leaves the occupancy at 1 and preserves order.
REQ-025 SYNC with no transfer: counter -> 0 and the partial word is discarded; the FIFO is untouched.
REQ-026 SYNC together with a transfer: the pair is taken as beat 0 of a new word, and FLIP is sampled at that beat.
REQ-027 SYNC while counter = 3 and the FIFO is full: the transfer is still blocked by IN_READY=0, and the counter still resets to 0.
REQ-028 The FIFO never overflows and never underflows; pointers wrap modulo 2 and a 2-bit count tracks 0..2.

Reset
REQ-029 RESET (synchronous) clears: beat counter = 0, FIFO count = 0, both pointers = 0, OUT_VALID = 0, IN_READY = 1, CR = 0, OPQ = 0, latched FLIP = 0.
REQ-030 RESET mid-word or with the FIFO occupied discards all data; RESET has priority over SYNC and over transfers.

Structure
REQ-031 The shared package holds: PIX_PER_WORD=8, BPP=4, BEATS_PER_WORD=4, FIFO_DEPTH=2, and a packed word typedef {cr[31:0], opq[7:0]}.
REQ-032 The 2-entry FIFO is one sub-module, zmc2_pack_fifo (40 bits wide, synchronous reset).
REQ-033 The pack-index function (pixel, bit, flip) -> CR index lives in the package, so the bench can reuse it.

Verification
REQ-034 FLIP=0, beats (A,B)=(1,2),(3,4),(5,6),(7,8), OUT_READY=1 -> CR=0x80_78_66_55, OPQ=0xFF, one cycle after beat 3.
REQ-035 Same beats with FLIP=1 on beat 0 -> CR=0x01_1E_66_AA, OPQ=0xFF.
REQ-036 All-zero pixels except pixel 5 = 0xF -> CR=0x20202020, OPQ=0x20.
REQ-037 OUT_READY=0, stream 3 words -> words 1-2 are buffered, IN_READY drops at word 3 beat 3; raise OUT_READY -> 3 words emerge in order with no loss.
REQ-038 Two beats, then SYNC, then 4 beats of word W -> only W is output; SYNC with a transfer -> that beat counts as beat 0.
REQ-039 RESET asserted mid-word with one word queued -> next cycle OUT_VALID=0, IN_READY=1, and a following 4-beat word is emitted correctly.
